// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the 6-digit clock display scanner:
// segment patterns, digit index enum, captured time bus and binary-to-BCD helper.
package clock_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  typedef enum logic [2:0] {
    IDX_S0 = 3'd0,
    IDX_S1 = 3'd1,
    IDX_M0 = 3'd2,
    IDX_M1 = 3'd3,
    IDX_H0 = 3'd4,
    IDX_H1 = 3'd5
  } digit_idx_t;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       set_time_mode;
  } time_bus_t;

  // Returns {tens, units}; valid for the full 0..63 input range.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = {2'b00, v} / 8'd10;
    units = {2'b00, v} % 8'd10;
    return (tens << 4) | units;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Codes 0-9 are decimal digits; CODE_DASH and CODE_BLANK come from clock_disp_pkg.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:       seg_o = SEG_0;
      4'd1:       seg_o = SEG_1;
      4'd2:       seg_o = SEG_2;
      4'd3:       seg_o = SEG_3;
      4'd4:       seg_o = SEG_4;
      4'd5:       seg_o = SEG_5;
      4'd6:       seg_o = SEG_6;
      4'd7:       seg_o = SEG_7;
      4'd8:       seg_o = SEG_8;
      4'd9:       seg_o = SEG_9;
      CODE_DASH:  seg_o = SEG_DASH;
      default:    seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Multiplexed 6-digit HH:MM:SS display driver with synchronised, stability-checked capture.
// Optional set-mode blinking of hours/minutes digits is enabled by CLOCK_DISP_BLINK_EN.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DIGIT_HZ  = 1_000,
  parameter int GUARD_CYC = 4,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_time_mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int PRESCALE     = CLK_HZ / DIGIT_HZ;
  localparam int PRE_W        = $clog2(PRESCALE);
  localparam int BLINK_PERIOD = CLK_HZ / BLINK_HZ;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] GUARD    = PRE_W'(GUARD_CYC);

  time_bus_t rawBus;
  time_bus_t sync1_q, sync2_q, prev_q, disp_q;

  assign rawBus = {hours, minutes, seconds, set_time_mode};

  // Only a bus seen identical on two consecutive synchronised samples is displayed,
  // so a multi-bit value caught mid-change never reaches the digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      disp_q  <= '0;
    end else begin
      sync1_q <= rawBus;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q == prev_q) disp_q <= sync2_q;
    end
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  digit_idx_t       idx_q, idx_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      case (idx_q)
        IDX_S0:  idx_d = IDX_S1;
        IDX_S1:  idx_d = IDX_M0;
        IDX_M0:  idx_d = IDX_M1;
        IDX_M1:  idx_d = IDX_H0;
        IDX_H0:  idx_d = IDX_H1;
        default: idx_d = IDX_S0;
      endcase
    end
  end

  logic blinkOff;

`ifdef CLOCK_DISP_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_PERIOD);
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;

  assign blinkCnt_d = (blinkCnt_q == BLINK_W'(BLINK_PERIOD - 1)) ? '0 : blinkCnt_q + 1'b1;
  assign blinkOff   = disp_q.set_time_mode && (blinkCnt_d < BLINK_W'(BLINK_PERIOD / 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blinkCnt_q <= '0;
    else          blinkCnt_q <= blinkCnt_d;
  end
`else
  logic unused_blink;
  assign blinkOff     = 1'b0;
  assign unused_blink = disp_q.set_time_mode ^ (BLINK_PERIOD == 0);
`endif

  logic [7:0] secBcd, minBcd, hrBcd;
  logic       secBad, minBad, hrBad;
  logic [3:0] code;
  logic [6:0] segEnc;

  assign secBcd = bin_to_bcd(disp_q.seconds);
  assign minBcd = bin_to_bcd(disp_q.minutes);
  assign hrBcd  = bin_to_bcd({1'b0, disp_q.hours});
  assign secBad = disp_q.seconds > 6'd59;
  assign minBad = disp_q.minutes > 6'd59;
  assign hrBad  = disp_q.hours > 5'd23;

  // Digit selection follows the index that will be current after this edge.
  always_comb begin
    code = CODE_BLANK;
    case (idx_d)
      IDX_S0:  code = secBad ? CODE_DASH : secBcd[3:0];
      IDX_S1:  code = secBad ? CODE_DASH : secBcd[7:4];
      IDX_M0:  code = minBad ? CODE_DASH : minBcd[3:0];
      IDX_M1:  code = minBad ? CODE_DASH : minBcd[7:4];
      IDX_H0:  code = hrBad  ? CODE_DASH : hrBcd[3:0];
      IDX_H1:  code = hrBad  ? CODE_DASH : hrBcd[7:4];
      default: code = CODE_BLANK;
    endcase
    if (blinkOff && idx_d != IDX_S0 && idx_d != IDX_S1) code = CODE_BLANK;
  end

  seg7_encode u_enc (
    .code_i (code),
    .seg_o  (segEnc)
  );

  logic [6:0] seg_q;
  logic [5:0] an_q;
  logic       dp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= IDX_S0;
      seg_q <= SEG_BLANK;
      an_q  <= 6'h3F;
      dp_q  <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      if (pre_d < GUARD) begin
        seg_q <= SEG_BLANK;
        an_q  <= 6'h3F;
        dp_q  <= 1'b1;
      end else begin
        seg_q <= segEnc;
        an_q  <= ~(6'b1 << idx_d);
        dp_q  <= ~((idx_d == IDX_M0) || (idx_d == IDX_H0));
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: stimulus pushes expected frames, a monitor
// pops one entry at the start of each lit dwell. Honours CLOCK_DISP_BLINK_EN.
module tb_clock_display_scan;

  localparam int CLK_HZ    = 1000;
  localparam int DIGIT_HZ  = 100;
  localparam int GUARD_CYC = 2;
  localparam int BLINK_HZ  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       set_time_mode = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       blinkable;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   edgeCount = 0;
  logic [5:0] prevAn = 6'h3F;

  clock_display_scan #(
    .CLK_HZ    (CLK_HZ),
    .DIGIT_HZ  (DIGIT_HZ),
    .GUARD_CYC (GUARD_CYC),
    .BLINK_HZ  (BLINK_HZ)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .seconds       (seconds),
    .minutes       (minutes),
    .hours         (hours),
    .set_time_mode (set_time_mode),
    .seg           (seg),
    .dp            (dp),
    .an            (an)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; equals the blink counter value driving the outputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgeCount <= 0;
    else          edgeCount <= edgeCount + 1;
  end

  // Monitor: one scoreboard entry per dwell, compared at the first lit cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] es;
    if (reset_n && an != 6'h3F && prevAn == 6'h3F && expQ.size() > 0) begin
      e  = expQ.pop_front();
      es = e.seg;
`ifdef CLOCK_DISP_BLINK_EN
      if (e.blinkable && (edgeCount % 100) < 50) es = 7'h7F;
`endif
      compared++;
      if (an !== e.an || seg !== es || dp !== e.dp) begin
        mismatched++;
        $display("[TB] FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 e.name, an, seg, dp, e.an, es, e.dp);
      end
    end
    prevAn = an;
  end

  task automatic checkOutput(input string name, input logic [5:0] expAn,
                             input logic [6:0] expSeg, input logic expDp);
    compared++;
    if (an !== expAn || seg !== expSeg || dp !== expDp) begin
      mismatched++;
      $display("[TB] FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               name, an, seg, dp, expAn, expSeg, expDp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] h, input logic [5:0] m,
                               input logic [5:0] s, input logic mode);
    @(negedge clk);
    hours = h;
    minutes = m;
    seconds = s;
    set_time_mode = mode;
    repeat (8) @(negedge clk);
  endtask

  // Returns once the display sits in the guard following the hours-tens dwell.
  task automatic syncFrame(input string name);
    int  n = 0;
    bit  seen5 = 0;
    bit  done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (an == 6'h1F) seen5 = 1;
      else if (seen5 && an == 6'h3F) done = 1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_sync: got no frame boundary, want one within 200 clk", name);
    end
  endtask

  task automatic pushFrame(input string name,
                           input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                           input logic blink);
    expQ.push_back('{6'h3E, s0, 1'b1, 1'b0,  {name, "_d0"}});
    expQ.push_back('{6'h3D, s1, 1'b1, 1'b0,  {name, "_d1"}});
    expQ.push_back('{6'h3B, s2, 1'b0, blink, {name, "_d2"}});
    expQ.push_back('{6'h37, s3, 1'b1, blink, {name, "_d3"}});
    expQ.push_back('{6'h2F, s4, 1'b0, blink, {name, "_d4"}});
    expQ.push_back('{6'h1F, s5, 1'b1, blink, {name, "_d5"}});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expQ.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_drain: got %0d entries left, want 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkFrame(input string name,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                            input logic blink);
    syncFrame(name);
    pushFrame(name, s0, s1, s2, s3, s4, s5, blink);
    drain(name);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_hold", 6'h3F, 7'h7F, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_guard", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk);
    checkOutput("rst_first", 6'h3E, 7'h40, 1'b1);

    // Asynchronous reset asserted in the middle of a lit dwell.
    repeat (23) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checkOutput("rst_async", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst2_guard", 6'h3F, 7'h7F, 1'b1);
    @(negedge clk);
    checkOutput("rst2_first", 6'h3E, 7'h40, 1'b1);

    applyStimulus(5'd12, 6'd34, 6'd56, 1'b0);
    checkFrame("t123456", 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);

    applyStimulus(5'd23, 6'd59, 6'd59, 1'b0);
    checkFrame("t235959", 7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24, 1'b0);
    applyStimulus(5'd0, 6'd0, 6'd0, 1'b0);
    checkFrame("t000000", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);

    applyStimulus(5'd24, 6'd60, 6'd7, 1'b0);
    checkFrame("t_range", 7'h78, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);

    // Bus toggling every clock must leave the last stable value on the display.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          @(negedge clk);
          if (i % 2 == 0) {hours, minutes, seconds} = {5'd5, 6'd6, 6'd7};
          else            {hours, minutes, seconds} = {5'd10, 6'd20, 6'd30};
        end
      end
      begin
        checkFrame("t_toggle", 7'h78, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
      end
    join
    applyStimulus(5'd5, 6'd6, 6'd7, 1'b0);
    checkFrame("t050607", 7'h78, 7'h40, 7'h02, 7'h40, 7'h12, 7'h40, 1'b0);

    applyStimulus(5'd12, 6'd34, 6'd56, 1'b1);
    checkFrame("t_set_a", 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 1'b1);
    checkFrame("t_set_b", 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
